// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and helpers for the multi-channel clock divider.
//               DIV_W_DEFAULT - default divide-value width
//               div_t         - divide value of default width
//               eff_div()     - maps a programmed ratio of 0 onto 1
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 16;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

    // A ratio of 0 would mean a 1-cycle period, which cannot carry both a
    // high and a low phase, so it is treated as the minimum ratio of 1.
    function automatic div_t eff_div(input div_t d);
        return (d == '0) ? div_t'(1) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_channel
// Description : One programmable divider channel. Period = max(div,1)+1
//               cycles; square wave is high for the first half (low-biased
//               for odd periods) and a tick marks the start of each period.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_en          - run enable
//               i_sync        - restart at phase 0 (only while enabled)
//               i_div         - requested ratio, sampled at period start
//               o_clk_out     - registered divided square wave
//               o_tick        - registered 1-cycle start-of-period pulse
//               o_busy        - channel running
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_busy
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_active_div;
    logic             r_run;
    logic             r_clk_out;
    logic             r_tick;

    logic [DIV_W-1:0] w_eff_div;
    logic [DIV_W:0]   w_cnt_nxt;
    logic [DIV_W:0]   w_half;
    logic             w_wrap;
    logic             w_start;

    generate
        if (DIV_W == DIV_W_DEFAULT) begin : g_pkg_eff
            assign w_eff_div = eff_div(i_div);
        end else begin : g_generic_eff
            assign w_eff_div = (i_div == '0) ? DIV_W'(1) : i_div;
        end
    endgenerate

    // One extra bit so active_div = 2^DIV_W-1 yields a period of 2^DIV_W
    // without the high-phase threshold wrapping to zero.
    assign w_cnt_nxt = {1'b0, r_cnt} + (DIV_W+1)'(1);
    assign w_half    = ({1'b0, r_active_div} + (DIV_W+1)'(1)) >> 1;

    assign w_wrap  = r_run && (r_cnt == r_active_div);
    // A sync landing on a wrap is one start, so the terms are simply ORed.
    assign w_start = i_en && (!r_run || i_sync || w_wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_active_div <= '0;
            r_run        <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else if (!i_en) begin
            // Disable wins over sync; any partial period is discarded.
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_start) begin
            // The ratio is only latched here, so a mid-period change to
            // i_div can never shorten or stretch the period in flight.
            r_cnt        <= '0;
            r_active_div <= w_eff_div;
            r_run        <= 1'b1;
            r_clk_out    <= 1'b1;
            r_tick       <= 1'b1;
        end else if (r_run) begin
            r_cnt     <= w_cnt_nxt[DIV_W-1:0];
            r_tick    <= 1'b0;
            r_clk_out <= (w_cnt_nxt < w_half);
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_busy    = r_run;

endmodule
`default_nettype wire

// File: rtl/multi_channel_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_clk_div
// Description : NUM_CH independent programmable clock dividers producing
//               registered clock-enables and square waves for the clk domain.
//               A common sync_all pulse phase-aligns every enabled channel.
// Ports       : clk      - system clock (rising edge)
//               rst      - asynchronous active-high reset
//               en       - per-channel run enable          [NUM_CH]
//               div      - per-channel ratio, channel c at div[c*DIV_W +: DIV_W]
//               sync_all - restart all enabled channels at phase 0
//               clk_out  - divided square waves             [NUM_CH]
//               tick     - start-of-period pulses           [NUM_CH]
//               busy     - channel running                  [NUM_CH]
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = DIV_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic                    sync_all,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       busy
);

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            clk_div_channel #(
                .DIV_W (DIV_W)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .i_en      (en[c]),
                .i_sync    (sync_all),
                .i_div     (div[c*DIV_W +: DIV_W]),
                .o_clk_out (clk_out[c]),
                .o_tick    (tick[c]),
                .o_busy    (busy[c])
            );
        end
    endgenerate

endmodule
`default_nettype wire
